// File: rtl/ip_tile_host_driver.sv
// Host-side responder for the uC_8bits IP tile: paces the tile's uC clock and
// serves its flash fetches and SRAM accesses sampled from data_reg_c.
module ip_tile_host_driver #(
  parameter int REG_WIDTH    = 32,
  parameter int PHASE_CYCLES = 2,
  parameter int FLASH_AW     = 12,
  parameter int SRAM_AW      = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 run,
  input  logic                 step,
  input  logic                 bp_en,
  input  logic [FLASH_AW-1:0]  bp_addr,
  input  logic                 prog_we,
  input  logic [FLASH_AW-1:0]  prog_addr,
  input  logic [15:0]          prog_data,
  input  logic [REG_WIDTH-1:0] data_reg_c,
  output logic [REG_WIDTH-1:0] data_reg_a,
  output logic [REG_WIDTH-1:0] data_reg_b,
  output logic                 busy,
  output logic                 halted,
  output logic [31:0]          uc_cycles
);
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOW, SAMPLE, READ, DRIVE, HIGH} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       phase_q, phase_d;
  logic                oneshot_q, oneshot_d;
  logic                halted_q, halted_d;
  logic                run_q;
  logic                uc_clk_q;
  logic [31:0]         uc_cycles_q;
  logic [FLASH_AW-1:0] pc_q;
  logic [SRAM_AW-1:0]  addr_q;
  logic                we_q;
  logic [7:0]          wdata_q;
  logic [15:0]         drv_b_q;
  logic [7:0]          drv_a_q;

  logic [15:0] flash_mem [2**FLASH_AW];
  logic [7:0]  sram_mem  [2**SRAM_AW];

  logic [FLASH_AW-1:0] c_pc;
  logic [SRAM_AW-1:0]  c_addr;
  logic                c_we;
  logic [7:0]          c_wdata;
  logic                unused_c;

  assign c_pc     = data_reg_c[16 +: FLASH_AW];
  assign c_addr   = data_reg_c[0 +: SRAM_AW];
  assign c_we     = data_reg_c[30];
  assign c_wdata  = data_reg_c[15:8];
  assign unused_c = ^data_reg_c;

  // Host controls are strobes with no acknowledge: step and prog_we take
  // effect only on a clk where busy is low, and are dropped otherwise.
  always_comb begin
    state_d   = state_q;
    oneshot_d = oneshot_q;
    halted_d  = halted_q;
    if (run_q && !run) halted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run && !halted_q) begin
          state_d = LOW;
        end else if (step) begin
          state_d   = LOW;
          oneshot_d = 1'b1;
          halted_d  = 1'b0;
        end
      end
      LOW: if (phase_q == PHASE_LAST) state_d = SAMPLE;
      SAMPLE: begin
        if (bp_en && (c_pc == bp_addr) && !oneshot_q) begin
          halted_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = READ;
        end
      end
      READ:  state_d = DRIVE;
      DRIVE: state_d = HIGH;
      HIGH: begin
        if (phase_q == PHASE_LAST) begin
          if (oneshot_q) begin
            oneshot_d = 1'b0;
            state_d   = IDLE;
          end else if (run && !halted_q) begin
            state_d = LOW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d = '0;
    if ((state_d == state_q) && ((state_q == LOW) || (state_q == HIGH)))
      phase_d = phase_q + CW'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      oneshot_q   <= 1'b0;
      halted_q    <= 1'b0;
      run_q       <= 1'b0;
      uc_clk_q    <= 1'b0;
      uc_cycles_q <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      drv_b_q     <= '0;
      drv_a_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      oneshot_q <= oneshot_d;
      halted_q  <= halted_d;
      run_q     <= run;
      // Registered so the uC clock is a clean flop output, high exactly in HIGH.
      uc_clk_q  <= (state_d == HIGH);
      if ((state_d == HIGH) && (state_q != HIGH)) uc_cycles_q <= uc_cycles_q + 32'd1;
      if (state_q == SAMPLE) begin
        pc_q    <= c_pc;
        addr_q  <= c_addr;
        we_q    <= c_we;
        wdata_q <= c_wdata;
      end
      // Read results land here so they are already stable during DRIVE.
      if (state_q == READ) begin
        drv_b_q <= flash_mem[pc_q];
        drv_a_q <= sram_mem[addr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && prog_we) flash_mem[prog_addr] <= prog_data;
    if ((state_q == READ) && we_q) sram_mem[addr_q] <= wdata_q;
  end

  always_comb begin
    data_reg_a       = '0;
    data_reg_a[9]    = uc_clk_q;
    data_reg_a[7:0]  = drv_a_q;
    data_reg_b       = '0;
    data_reg_b[15:0] = drv_b_q;
  end

  assign busy      = (state_q != IDLE);
  assign halted    = halted_q;
  assign uc_cycles = uc_cycles_q;

endmodule

// File: doc/ip_tile_host_driver.md
Name: ip_tile_host_driver

Overview:
Host-side responder for the uC_8bits IP tile register interface. It generates the tile's uC clock on data_reg_a[9]. Each uC cycle it samples the tile's requests from data_reg_c (PC, SRAM address, write enable, write data), serves flash words from an internal program ROM on data_reg_b[15:0], and serves SRAM read data on data_reg_a[7:0]. It sits between the host bus (program load, run/step/breakpoint control) and the tile's data_reg_a/b/c ports.

Parameters:
REG_WIDTH, 32, width of data_reg_a/b/c
PHASE_CYCLES, 2, clk cycles that the uC clock is held in each of LOW and HIGH (min 1)
FLASH_AW, 12, flash address width (depth 2**FLASH_AW x 16 bits)
SRAM_AW, 8, SRAM address width (depth 2**SRAM_AW x 8 bits)

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-high
run  in  1  level; free-run the uC while high
step  in  1  single-cycle pulse; one uC rising edge when in IDLE
bp_en  in  1  breakpoint enable
bp_addr  in  FLASH_AW  breakpoint PC
prog_we  in  1  flash program write strobe
prog_addr  in  FLASH_AW  flash program write address
prog_data  in  16  flash program write data
data_reg_c  in  REG_WIDTH  tile status: [31] boot, [30] sram_we, [29] cu_state, [28] pc_valid, [27:16] pc, [15:8] sram wdata, [7:0] sram addr
data_reg_a  out  REG_WIDTH  [9] uC clock, [7:0] SRAM read data, all other bits 0
data_reg_b  out  REG_WIDTH  [15:0] flash word, all other bits 0
busy  out  1  high in any state other than IDLE
halted  out  1  sticky; set on breakpoint hit
uc_cycles  out  32  count of uC rising edges issued

Behaviour:
- Reset (arst high, async): state IDLE; data_reg_a=0, data_reg_b=0 (uC clock low); busy=0; halted=0; uc_cycles=0; all sample registers 0. Memory contents are not cleared. Reset mid-cycle aborts immediately with the uC clock forced low.
- FSM states: IDLE, LOW, SAMPLE, READ, DRIVE, HIGH.
- IDLE: uC clock low. If run=1 and halted=0 -> LOW. Else if step=1 -> LOW with a one-shot flag set. run has priority over step. A step arriving outside IDLE is ignored. halted is cleared when step is accepted or when run goes 1->0.
- LOW: uC clock low for PHASE_CYCLES clks so tile combinational outputs settle; then -> SAMPLE.
- SAMPLE (1 clk): register pc=data_reg_c[16+FLASH_AW-1:16], addr=data_reg_c[SRAM_AW-1:0], we=data_reg_c[30], wdata=data_reg_c[15:8].
  - If bp_en and pc==bp_addr and the one-shot flag is 0: set halted and go -> IDLE. No rising edge is issued and data outputs are unchanged.
  - Else -> READ.
- READ (1 clk): synchronous reads flash[pc] and sram[addr]. If we=1, write sram[addr]<=wdata in the same clk. Read-before-write: the read returns the old value.
- DRIVE (1 clk): register read data onto data_reg_b[15:0] and data_reg_a[7:0], uC clock still low. This gives a setup window before the edge. -> HIGH.
- HIGH: data_reg_a[9]=1 for PHASE_CYCLES clks. uc_cycles increments by 1 on entry and wraps at 2**32. On exit the uC clock goes low.
  - If one-shot flag set: clear it -> IDLE.
  - Else if run=1 and halted=0 -> LOW.
  - Else -> IDLE.
- Dropping run mid-cycle always completes the current uC cycle through HIGH before entering IDLE.
- uC cycle period: 2*PHASE_CYCLES+3 clks (7 at default).
- prog_we is accepted only in IDLE (flash[prog_addr]<=prog_data). It is silently ignored while busy. Flash is single-port for the host; no read-back.
- Addresses wrap naturally at their widths. Upper bits of data_reg_c above the used fields are ignored.

Test Plan:
- Reset then idle: assert arst mid-HIGH -> data_reg_a[9]=0 within the same clk; busy=0, uc_cycles=0.
- Program load then step: write flash[0x000]=0xA5C3 in IDLE; data_reg_c pc=0x000; pulse step -> exactly one rising edge 5 clks after the step; data_reg_b=0x0000A5C3 stable from the DRIVE clk; uc_cycles=1; busy returns to 0 after HIGH.
- SRAM write/read: cycle 1 with data_reg_c addr=0x10, we=1, wdata=0x5A -> data_reg_a[7:0] shows the old value. Cycle 2 with addr=0x10, we=0 -> data_reg_a[7:0]=0x5A.
- Free run: run=1 for 70 clks (PHASE_CYCLES=2) -> 10 rising edges at a 7-clk period. Dropping run in the middle of a HIGH phase completes that HIGH before IDLE; uc_cycles=10.
- Breakpoint: bp_en=1, bp_addr=0x004, tile pc reaches 0x004 -> halted=1, no edge issued at that PC, IDLE. A following step executes that one cycle despite the breakpoint, then returns to IDLE.
- Program write while busy: prog_we during run -> flash content unchanged (verified by a later step fetch).
